memoria_ram: RTL and testbench
==============================

Name: memoria_ram

Overview:
- Parametrised single-port synchronous RAM of DEPTH words × WIDTH bits.
- Successor to the fixed 2-word × 8-bit flip-flop memory. Adds:
  - configurable width and depth;
  - a request/ready handshake;
  - registered read data with a valid flag;
  - a hardware zero-fill sequencer that clears every word after reset or on command.
- Sits between the datapath/control unit and local storage, as the general-purpose register/scratch memory of the teaching CPU.

Parameters:
- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 4: number of words (≥2; need not be a power of two).
- ADDR_W, $clog2(DEPTH): address width. Derived; must not be overridden.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- clear_n  input  1  asynchronous active-low reset.
- req  input  1  access request, sampled on posedge when ready=1.
- rw  input  1  1 = write, 0 = read; qualified by req.
- addr  input  ADDR_W  word address.
- din  input  WIDTH  write data.
- clear_mem  input  1  synchronous command to zero-fill the whole array.
- ready  output  1  1 = an access is accepted this cycle.
- dout  output  WIDTH  registered read data.
- dout_valid  output  1  one-cycle pulse; dout holds new read data.
- addr_err  output  1  one-cycle pulse; an accepted access had addr ≥ DEPTH.

Behaviour:
- Reset, clock and reset ports:
  - One clock, clk.
  - Reset clear_n is asynchronous and active-low.
  - While clear_n=0: ready=0, dout=0, dout_valid=0, addr_err=0, state=FILL, fill counter=0. Array contents are undefined until FILL completes.
- States: FILL, IDLE.
  - FILL:
    - Each posedge writes 0 to word[fill_cnt] and increments fill_cnt.
    - After writing word DEPTH-1, go to IDLE. FILL takes exactly DEPTH cycles after clear_n deasserts.
    - ready=0 throughout; req is ignored; dout holds its value; dout_valid=0.
  - IDLE:
    - ready=1.
    - clear_mem=1 at a posedge → FILL with fill_cnt=0. A simultaneous req is ignored (not accepted). ready drops the following cycle.
- Write (IDLE, req=1, rw=1, addr<DEPTH):
  - word[addr] ← din at that posedge.
  - dout and dout_valid are unchanged (dout_valid=0).
- Read (IDLE, req=1, rw=0, addr<DEPTH):
  - dout ← word[addr] at that posedge.
  - dout_valid=1 for exactly the following cycle. Latency = 1 cycle.
  - Back-to-back reads are allowed every cycle; dout_valid stays high.
- Read-after-write to the same address on consecutive cycles returns the newly written data (no bypass is needed, because the write completes first).
- Out-of-range (addr ≥ DEPTH, possible when DEPTH is not a power of two):
  - Write is discarded.
  - Read returns dout=0 with dout_valid=1.
  - addr_err=1 for one cycle in both cases.
- req=0 in IDLE: no state change; dout holds; dout_valid=0.
- clear_n asserted mid-FILL or mid-access: immediate abort to the reset values; FILL restarts from word 0.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset and fill: clear_n=0 for 2 cycles, then 1, WIDTH=8, DEPTH=4 → ready=0 for exactly 4 posedges, then ready=1. Reads of addr 0..3 each return 8'h00 with dout_valid one cycle after req.
- Write/read: write 8'h25 @0, 8'h07 @1, 8'h76 @2, 8'h36 @3, then read 3,2,1,0 back-to-back → dout = 36, 76, 07, 25 on consecutive cycles; dout_valid high for 4 cycles.
- Read-after-write: write 8'hA5 @2, next cycle read @2 → dout=8'hA5 one cycle later. A write with req=0 (rw=1, din=8'hFF) leaves word 2 at 8'hA5.
- clear_mem: fill all words with nonzero data, pulse clear_mem together with a read req → req not accepted, ready=0 for 4 cycles. All subsequent reads return 8'h00.
- Out of range: DEPTH=5, ADDR_W=3. Write 8'h11 @6 → addr_err pulse, no array change. Read @6 → dout=0, dout_valid=1, addr_err=1. Read @4 returns its prior value.
- Reset mid-FILL and mid-read: assert clear_n=0 at FILL cycle 2 and later during a read → outputs go to 0 asynchronously, no dout_valid pulse. After release, FILL again takes the full DEPTH cycles.

Source files
------------

// File: rtl/memoria_ram.sv
// Single-port synchronous RAM with request/ready handshake, registered read data,
// and a zero-fill sequencer that clears every word after reset or on command.
module memoria_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    input  logic              clear_mem,
    output logic              ready,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              addr_err
);

    typedef enum logic {FILL, IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] fill_next;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              in_range;
    logic              accept;

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign accept   = (state == IDLE) && req && !clear_mem;
    assign ready    = (state == IDLE);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= FILL;
            fill_cnt <= '0;
        end else begin
            state    <= state_next;
            fill_cnt <= fill_next;
        end
    end

    always_comb begin
        state_next = state;
        fill_next  = fill_cnt;
        case (state)
            FILL: begin
                if (fill_cnt == LAST_ADDR) begin
                    state_next = IDLE;
                    fill_next  = '0;
                end else begin
                    fill_next = fill_cnt + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clear_mem) begin
                    state_next = FILL;
                    fill_next  = '0;
                end
            end
            default: begin
                state_next = FILL;
                fill_next  = '0;
            end
        endcase
    end

    // Storage carries no reset; the fill sequencer defines its contents.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            mem[fill_cnt] <= '0;
        end else if (accept && rw && in_range) begin
            mem[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            dout_valid <= accept && !rw;
            addr_err   <= accept && !in_range;
            if (accept && !rw) begin
                dout <= in_range ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_memoria_ram.sv
// Directed bench for memoria_ram: a DEPTH=4 instance for the main function and a
// DEPTH=5 instance for the out-of-range hole, checked against a per-cycle scoreboard.
module tb_memoria_ram;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       a_clear_n, a_req, a_rw, a_clear_mem, a_ready, a_dout_valid, a_addr_err;
    logic [1:0] a_addr;
    logic [7:0] a_din, a_dout;
    logic       b_clear_n, b_req, b_rw, b_clear_mem, b_ready, b_dout_valid, b_addr_err;
    logic [2:0] b_addr;
    logic [7:0] b_din, b_dout;

    int         total;
    int         passed;
    int         failed;
    int         sel;
    exp_t       sb [$];
    logic [7:0] mmem [2][5];
    int         fill_left [2];
    logic [7:0] mdout [2];

    memoria_ram #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .clear_n(a_clear_n), .req(a_req), .rw(a_rw), .addr(a_addr),
        .din(a_din), .clear_mem(a_clear_mem), .ready(a_ready), .dout(a_dout),
        .dout_valid(a_dout_valid), .addr_err(a_addr_err)
    );

    memoria_ram #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .clear_n(b_clear_n), .req(b_req), .rw(b_rw), .addr(b_addr),
        .din(b_din), .clear_mem(b_clear_mem), .ready(b_ready), .dout(b_dout),
        .dout_valid(b_dout_valid), .addr_err(b_addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int depth_of();
        return (sel == 0) ? 4 : 5;
    endfunction

    function automatic logic [7:0] o_dout();
        return (sel == 0) ? a_dout : b_dout;
    endfunction

    function automatic logic o_valid();
        return (sel == 0) ? a_dout_valid : b_dout_valid;
    endfunction

    function automatic logic o_err();
        return (sel == 0) ? a_addr_err : b_addr_err;
    endfunction

    function automatic logic o_ready();
        return (sel == 0) ? a_ready : b_ready;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic req, input logic rw, input logic [2:0] addr,
                         input logic [7:0] din, input logic cm);
        if (sel == 0) begin
            a_req = req; a_rw = rw; a_addr = addr[1:0]; a_din = din; a_clear_mem = cm;
        end else begin
            b_req = req; b_rw = rw; b_addr = addr; b_din = din; b_clear_mem = cm;
        end
    endtask

    task automatic set_clear_n(input logic v);
        if (sel == 0) a_clear_n = v;
        else b_clear_n = v;
    endtask

    task automatic reset_model();
        fill_left[sel] = depth_of();
        mdout[sel]     = 8'h00;
        sb.delete();
        for (int i = 0; i < 5; i++) mmem[sel][i] = 8'h00;
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic do_cycle(input logic req, input logic rw, input logic [2:0] addr,
                            input logic [7:0] din, input logic cm);
        exp_t e;
        exp_t got;
        logic acc;
        logic inr;
        check("ready", {7'b0, o_ready()}, {7'b0, fill_left[sel] == 0});
        drive(req, rw, addr, din, cm);
        acc    = (fill_left[sel] == 0) && req && !cm;
        inr    = int'(addr) < depth_of();
        e      = '0;
        e.data = mdout[sel];
        if (fill_left[sel] > 0) begin
            fill_left[sel]--;
        end else if (cm) begin
            fill_left[sel] = depth_of();
            for (int i = 0; i < 5; i++) mmem[sel][i] = 8'h00;
        end else if (acc) begin
            e.err = !inr;
            if (rw) begin
                if (inr) mmem[sel][addr] = din;
            end else begin
                e.valid    = 1'b1;
                e.data     = inr ? mmem[sel][addr] : 8'h00;
                mdout[sel] = e.data;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("dout_valid", {7'b0, o_valid()}, {7'b0, got.valid});
        check("addr_err", {7'b0, o_err()}, {7'b0, got.err});
        check("dout", o_dout(), got.data);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        set_clear_n(1'b0);
        #1;
        check("rst_ready", {7'b0, o_ready()}, 8'h00);
        check("rst_dout", o_dout(), 8'h00);
        check("rst_valid", {7'b0, o_valid()}, 8'h00);
        check("rst_err", {7'b0, o_err()}, 8'h00);
        repeat (n) @(negedge clk);
        set_clear_n(1'b1);
        reset_model();
    endtask

    initial begin
        total = 0; passed = 0; failed = 0; sel = 0;
        a_clear_n = 1'b0; a_req = 1'b0; a_rw = 1'b0; a_addr = '0; a_din = '0; a_clear_mem = 1'b0;
        b_clear_n = 1'b0; b_req = 1'b0; b_rw = 1'b0; b_addr = '0; b_din = '0; b_clear_mem = 1'b0;
        for (int s = 0; s < 2; s++) begin
            fill_left[s] = 0;
            mdout[s]     = 8'h00;
            for (int i = 0; i < 5; i++) mmem[s][i] = 8'h00;
        end
        @(negedge clk);

        $display("[TB] reset and fill, DEPTH=4");
        do_reset(2);
        repeat (5) do_cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);

        $display("[TB] write then back-to-back reads");
        do_cycle(1'b1, 1'b1, 3'd0, 8'h25, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd1, 8'h07, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd2, 8'h76, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd3, 8'h36, 1'b0);
        for (int i = 3; i >= 0; i--) do_cycle(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);
        do_cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        $display("[TB] read-after-write and write without req");
        do_cycle(1'b1, 1'b1, 3'd2, 8'hA5, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
        do_cycle(1'b0, 1'b1, 3'd2, 8'hFF, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);

        $display("[TB] clear_mem with simultaneous read");
        do_cycle(1'b1, 1'b1, 3'd0, 8'h11, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd1, 8'h22, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd2, 8'h33, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd3, 8'h44, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd1, 8'h00, 1'b1);
        repeat (4) do_cycle(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 3'(i), 8'h00, 1'b0);

        $display("[TB] reset during a read");
        do_cycle(1'b1, 1'b1, 3'd1, 8'h5A, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        #2;
        a_clear_n = 1'b0;
        #1;
        check("async_dout", a_dout, 8'h00);
        check("async_valid", {7'b0, a_dout_valid}, 8'h00);
        check("async_ready", {7'b0, a_ready}, 8'h00);
        @(posedge clk);
        #1;
        check("held_valid", {7'b0, a_dout_valid}, 8'h00);
        check("held_dout", a_dout, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        a_clear_n = 1'b1;
        reset_model();

        $display("[TB] reset during fill");
        repeat (2) do_cycle(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        do_reset(1);
        repeat (5) do_cycle(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd1, 8'hC3, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);

        $display("[TB] out-of-range accesses, DEPTH=5");
        sel = 1;
        do_reset(2);
        repeat (6) do_cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd4, 8'h44, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd6, 8'h11, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
        do_cycle(1'b1, 1'b1, 3'd5, 8'h99, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        do_cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
